// File: rtl/fft_peak_detect.sv
// fft_peak_detect
// Streaming spectral peak finder placed directly after the FFT core. It
// consumes one FFT frame per sop..eop burst, squares each bin, and keeps the
// strongest bin in MIN_BIN..MAX_BIN. At frame end it emits a one-cycle report.
//
// Ports
//   CLOCK_50      in   system clock, rising edge
//   resetn        in   asynchronous active-low reset
//   source_valid  in   FFT beat valid
//   source_sop    in   first beat of frame (bin 0)
//   source_eop    in   last beat of frame (bin N_POINTS-1)
//   source_real   in   signed real part
//   source_imag   in   signed imaginary part
//   source_ready  out  back-pressure to FFT (registered, 1 after reset)
//   peak_valid    out  one-cycle pulse when peak_* are updated
//   peak_found    out  best magnitude reached the threshold and is non-zero
//   peak_bin      out  winning bin, 0 when not found
//   peak_mag      out  winning squared magnitude
//   frame_err     out  one-cycle pulse on malformed frame
module fft_peak_detect #(
  parameter int DATA_W   = 16,
  parameter int N_POINTS = 8192,
  parameter int BIN_W    = 13,
  parameter int MIN_BIN  = 1,
  parameter int MAX_BIN  = N_POINTS/2 - 1,
  parameter logic [2*DATA_W:0] MAG_THRESH = '0
) (
  input  logic                     CLOCK_50,
  input  logic                     resetn,
  input  logic                     source_valid,
  input  logic                     source_sop,
  input  logic                     source_eop,
  input  logic signed [DATA_W-1:0] source_real,
  input  logic signed [DATA_W-1:0] source_imag,
  output logic                     source_ready,
  output logic                     peak_valid,
  output logic                     peak_found,
  output logic [BIN_W-1:0]         peak_bin,
  output logic [2*DATA_W:0]        peak_mag,
  output logic                     frame_err
);

  localparam int SQ_W  = 2*DATA_W;
  localparam int MAG_W = 2*DATA_W + 1;
  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(N_POINTS - 1);
  localparam logic [BIN_W-1:0] MIN_B    = BIN_W'(MIN_BIN);
  localparam logic [BIN_W-1:0] MAX_B    = BIN_W'(MAX_BIN);

  typedef enum logic {ST_IDLE, ST_FRAME} state_t;

  state_t             r_state;
  logic [BIN_W-1:0]   r_cnt;      // bin index of the next beat in FRAME
  logic               r_ready;
  logic               r_frame_err;

  // stage 1
  logic               r_s1_valid;
  logic               r_s1_start;
  logic               r_s1_last;
  logic               r_s1_in_range;
  logic [BIN_W-1:0]   r_s1_bin;
  logic [SQ_W-1:0]    r_s1_re2;
  logic [SQ_W-1:0]    r_s1_im2;

  // stage 2
  logic [MAG_W-1:0]   r_best_mag;
  logic [BIN_W-1:0]   r_best_bin;
  logic               r_s2_report;

  // stage 3
  logic               r_peak_valid;
  logic               r_peak_found;
  logic [BIN_W-1:0]   r_peak_bin;
  logic [MAG_W-1:0]   r_peak_mag;

  logic               w_accept;
  logic               w_start;
  logic               w_cont;
  logic               w_at_last;
  logic               w_good_end;
  logic               w_err;
  logic [BIN_W-1:0]   w_beat_bin;
  logic signed [SQ_W-1:0] w_re2;
  logic signed [SQ_W-1:0] w_im2;
  logic [MAG_W-1:0]   w_mag;
  logic [MAG_W-1:0]   w_base_mag;
  logic [BIN_W-1:0]   w_base_bin;
  logic               w_take;
  logic               w_found;

  assign w_accept   = source_valid & r_ready;
  // A lone sop starts a frame; sop+eop together is always malformed.
  assign w_start    = w_accept & source_sop & ~source_eop;
  assign w_cont     = w_accept & ~source_sop & (r_state == ST_FRAME);
  assign w_at_last  = (r_cnt == LAST_BIN);
  assign w_good_end = w_cont & source_eop & w_at_last;
  // eop must coincide exactly with the last bin; either without the other is an error
  assign w_err      = w_accept & ((source_sop & source_eop) |
                                  (source_sop & (r_state == ST_FRAME)) |
                                  (w_cont & (source_eop ^ w_at_last)));
  assign w_beat_bin = w_start ? '0 : r_cnt;

  // Operands are sign-extended to SQ_W by the context, so the most negative
  // input squares exactly.
  assign w_re2 = source_real * source_real;
  assign w_im2 = source_imag * source_imag;

  assign w_mag      = {1'b0, r_s1_re2} + {1'b0, r_s1_im2};
  // The first beat of a frame compares against a cleared best, so the
  // previous frame's best stays intact until this very edge.
  assign w_base_mag = r_s1_start ? '0 : r_best_mag;
  assign w_base_bin = r_s1_start ? '0 : r_best_bin;
  assign w_take     = r_s1_in_range & (w_mag > w_base_mag);
  // A zero best was never updated, so it cannot name a real peak.
  assign w_found    = (r_best_mag >= MAG_THRESH) & (r_best_mag != '0);

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_ready     <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_ready     <= 1'b1;
      r_frame_err <= w_err;
      if (w_start) begin
        r_state <= ST_FRAME;
        r_cnt   <= BIN_W'(1);
      end else if (w_cont) begin
        if (source_eop || w_at_last) begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + BIN_W'(1);
        end
      end else if (w_accept && source_sop && source_eop) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_s1_valid    <= 1'b0;
      r_s1_start    <= 1'b0;
      r_s1_last     <= 1'b0;
      r_s1_in_range <= 1'b0;
      r_s1_bin      <= '0;
      r_s1_re2      <= '0;
      r_s1_im2      <= '0;
    end else begin
      r_s1_valid    <= w_start | w_cont;
      r_s1_start    <= w_start;
      r_s1_last     <= w_good_end;
      r_s1_in_range <= (w_beat_bin >= MIN_B) & (w_beat_bin <= MAX_B);
      r_s1_bin      <= w_beat_bin;
      r_s1_re2      <= w_re2;
      r_s1_im2      <= w_im2;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_best_mag  <= '0;
      r_best_bin  <= '0;
      r_s2_report <= 1'b0;
    end else begin
      r_s2_report <= r_s1_valid & r_s1_last;
      if (r_s1_valid) begin
        r_best_mag <= w_take ? w_mag    : w_base_mag;
        r_best_bin <= w_take ? r_s1_bin : w_base_bin;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_peak_valid <= 1'b0;
      r_peak_found <= 1'b0;
      r_peak_bin   <= '0;
      r_peak_mag   <= '0;
    end else begin
      r_peak_valid <= r_s2_report;
      if (r_s2_report) begin
        r_peak_found <= w_found;
        r_peak_bin   <= w_found ? r_best_bin : '0;
        r_peak_mag   <= r_best_mag;
      end
    end
  end

  assign source_ready = r_ready;
  assign frame_err    = r_frame_err;
  assign peak_valid   = r_peak_valid;
  assign peak_found   = r_peak_found;
  assign peak_bin     = r_peak_bin;
  assign peak_mag     = r_peak_mag;

endmodule

// File: tb/tb_fft_peak_detect.sv
// Scoreboard bench: the stimulus process pushes hand-computed expected
// reports/errors (with the cycle they must appear in) into queues; a monitor
// on the falling edge pops and compares whenever the DUTs present output.
// Two instances share the stimulus: threshold 0 and threshold 50000.
module tb_fft_peak_detect;

  logic        clk = 1'b0;
  logic        resetn;
  logic        source_valid, source_sop, source_eop;
  logic signed [15:0] source_real, source_imag;
  logic        rdy0, pv0, pf0, fe0;
  logic [5:0]  pb0;
  logic [32:0] pm0;
  logic        rdy1, pv1, pf1, fe1;
  logic [5:0]  pb1;
  logic [32:0] pm1;

  fft_peak_detect #(.DATA_W(16), .N_POINTS(64), .BIN_W(6), .MIN_BIN(1),
                    .MAX_BIN(31), .MAG_THRESH(33'd0)) dut0 (
    .CLOCK_50(clk), .resetn(resetn), .source_valid(source_valid),
    .source_sop(source_sop), .source_eop(source_eop),
    .source_real(source_real), .source_imag(source_imag),
    .source_ready(rdy0), .peak_valid(pv0), .peak_found(pf0),
    .peak_bin(pb0), .peak_mag(pm0), .frame_err(fe0));

  fft_peak_detect #(.DATA_W(16), .N_POINTS(64), .BIN_W(6), .MIN_BIN(1),
                    .MAX_BIN(31), .MAG_THRESH(33'd50000)) dut1 (
    .CLOCK_50(clk), .resetn(resetn), .source_valid(source_valid),
    .source_sop(source_sop), .source_eop(source_eop),
    .source_real(source_real), .source_imag(source_imag),
    .source_ready(rdy1), .peak_valid(pv1), .peak_found(pf1),
    .peak_bin(pb1), .peak_mag(pm1), .frame_err(fe1));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int     cyc;
    bit     found;
    int     bin;
    longint mag;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   qerr[$];
  int   checks = 0;
  int   failures = 0;
  int   fre[64];
  int   fim[64];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic cmp_report(input string who, input bit pf, input logic [5:0] pb,
                            input logic [32:0] pm, inout exp_t q[$]);
    exp_t e;
    if (q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s_unexpected_peak actual=bin%0d/mag%0d expected=no_report", who, pb, pm);
    end else begin
      e = q.pop_front();
      $display("%s report cycle=%0d found=%0d bin=%0d mag=%0d", who, cyc, pf, pb, pm);
      chk({who, "_peak_cycle"}, cyc, e.cyc);
      chk({who, "_peak_found"}, pf, e.found);
      chk({who, "_peak_bin"}, pb, e.bin);
      chk({who, "_peak_mag"}, pm, e.mag);
    end
  endtask

  // Monitor: decoupled from the stimulus, compares whatever the DUTs emit.
  always @(negedge clk) begin
    if (resetn) begin
      if (pv0) cmp_report("dut0", pf0, pb0, pm0, q0);
      if (pv1) cmp_report("dut1", pf1, pb1, pm1, q1);
      if (fe0) begin
        if (qerr.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_frame_err actual=1 expected=0 (cycle %0d)", cyc);
        end else begin
          $display("frame_err cycle=%0d", cyc);
          chk("frame_err_cycle", cyc, qerr.pop_front());
        end
      end
    end
  end

  task automatic clr();
    for (int i = 0; i < 64; i++) begin
      fre[i] = 0;
      fim[i] = 0;
    end
  endtask

  task automatic idle(input int n);
    source_valid = 1'b0;
    source_sop   = 1'b0;
    source_eop   = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic beat(input bit sop, input bit eop, input int re, input int im,
                      output int c);
    source_valid = 1'b1;
    source_sop   = sop;
    source_eop   = eop;
    source_real  = 16'(re);
    source_imag  = 16'(im);
    c = cyc;
    @(posedge clk);
    #1;
  endtask

  // Full 64-beat frame from fre/fim; optional one-cycle valid gap before beat gap_at.
  task automatic send_frame(input int gap_at, output int eop_c);
    int c;
    for (int b = 0; b < 64; b++) begin
      if (b == gap_at) idle(1);
      beat(b == 0, b == 63, fre[b], fim[b], c);
    end
    eop_c = c;
  endtask

  task automatic expect_peak(input int eop_c, input bit f0, input int b0, input longint m0,
                             input bit f1, input int b1, input longint m1);
    exp_t e;
    e.cyc = eop_c + 3; e.found = f0; e.bin = b0; e.mag = m0;
    q0.push_back(e);
    e.found = f1; e.bin = b1; e.mag = m1;
    q1.push_back(e);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!rdy0 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("source_ready_wait", rdy0, 1);
  endtask

  initial begin
    int c;
    resetn = 1'b0;
    source_valid = 1'b0; source_sop = 1'b0; source_eop = 1'b0;
    source_real = '0; source_imag = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", rdy0, 0);
    chk("reset_peak_valid", pv0, 0);
    chk("reset_peak_found", pf0, 0);
    chk("reset_peak_bin", pb0, 0);
    chk("reset_peak_mag", pm0, 0);
    chk("reset_frame_err", fe0, 0);
    #2 resetn = 1'b1;
    #1 chk("ready_before_edge", rdy0, 0);
    @(posedge clk);
    #1 chk("ready_after_edge", rdy0, 1);

    // Beats without sop in IDLE (including a stray eop) are ignored.
    beat(0, 0, 5000, 5000, c);
    beat(0, 1, 6000, 0, c);
    idle(2);

    // Single tone at bin 10: 300^2 + 400^2 = 250000.
    clr(); fre[10] = 300; fim[10] = -400;
    send_frame(-1, c);
    expect_peak(c, 1, 10, 250000, 1, 10, 250000);
    idle(3);

    // DC and mirror excluded, tie keeps the lower bin: 200^2 = 40000.
    clr(); fre[0] = 1000; fre[50] = 900; fim[5] = -200; fim[7] = -200;
    send_frame(-1, c);
    expect_peak(c, 1, 5, 40000, 0, 0, 40000);
    idle(2);

    // Threshold: (100,100) -> 20000, below 50000 on dut1.
    clr(); fre[12] = 100; fim[12] = 100;
    send_frame(-1, c);
    expect_peak(c, 1, 12, 20000, 0, 0, 20000);
    idle(2);

    // All-zero frame: nothing found.
    clr();
    send_frame(-1, c);
    expect_peak(c, 0, 0, 0, 0, 0, 0);
    idle(2);

    // Early eop on bin 40 -> error, no report.
    clr(); fre[20] = 3000;
    for (int b = 0; b <= 40; b++) beat(b == 0, b == 40, fre[b], fim[b], c);
    qerr.push_back(c + 1);
    idle(2);
    // Good frame, tone at bin 3 (600^2 = 360000), with a valid gap mid-frame.
    clr(); fre[3] = 600;
    send_frame(5, c);
    expect_peak(c, 1, 3, 360000, 1, 3, 360000);
    idle(2);

    // sop at bin 20 restarts the frame; the discarded big bin 10 must not leak.
    clr(); fre[10] = 2000;
    for (int b = 0; b < 20; b++) beat(b == 0, 1'b0, fre[b], fim[b], c);
    clr(); fim[15] = 700;
    qerr.push_back(cyc + 1);
    send_frame(-1, c);
    expect_peak(c, 1, 15, 490000, 1, 15, 490000);
    idle(2);

    // sop together with eop is malformed.
    beat(1, 1, 100, 100, c);
    qerr.push_back(c + 1);
    idle(2);

    // 64 beats without eop -> error on the last bin.
    clr(); fre[4] = 700;
    for (int b = 0; b < 64; b++) beat(b == 0, 1'b0, fre[b], fim[b], c);
    qerr.push_back(c + 1);
    idle(2);

    // Back-to-back frames: bin 8 (500,500) -> 500000, bin 22 (-1000,0) -> 1000000,
    // then extreme (-32768,-32768) at bin 9 -> 2^31.
    clr(); fre[8] = 500; fim[8] = 500;
    send_frame(-1, c);
    expect_peak(c, 1, 8, 500000, 1, 8, 500000);
    clr(); fre[22] = -1000;
    send_frame(-1, c);
    expect_peak(c, 1, 22, 1000000, 1, 22, 1000000);
    clr(); fre[9] = -32768; fim[9] = -32768;
    send_frame(-1, c);
    expect_peak(c, 1, 9, 64'd2147483648, 1, 9, 64'd2147483648);
    idle(6);

    // Reset mid-frame while bin 30 is on the bus.
    clr(); fre[10] = 2000;
    for (int b = 0; b < 30; b++) beat(b == 0, 1'b0, fre[b], fim[b], c);
    source_valid = 1'b1; source_sop = 1'b0; source_eop = 1'b0;
    #2 resetn = 1'b0;
    #1;
    chk("midreset_ready", rdy0, 0);
    chk("midreset_peak_bin", pb0, 0);
    chk("midreset_peak_mag", pm0, 0);
    chk("midreset_peak_found", pf0, 0);
    chk("midreset_peak_valid", pv0, 0);
    source_valid = 1'b0;
    @(posedge clk);
    #3 resetn = 1'b1;
    #1 chk("midreset_ready_before_edge", rdy0, 0);
    @(posedge clk);
    #1 wait_ready();
    idle(4);

    // MAX_BIN boundary: bin 31 (0,-300)=90000 beats bin 30 (0,299)=89401; bin 32 excluded.
    clr(); fim[30] = 299; fim[31] = -300; fim[32] = 1000;
    send_frame(-1, c);
    expect_peak(c, 1, 31, 90000, 1, 31, 90000);
    idle(8);

    chk("pending_dut0_reports", q0.size(), 0);
    chk("pending_dut1_reports", q1.size(), 0);
    chk("pending_frame_errs", qerr.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
